mult_limb_seq: RTL and testbench
================================

Name: mult_limb_seq

Overview:
- Sequencer that runs a wide 149 x (64*NUM_LIMBS) unsigned multiply on a single external 149x64 multiplier.
- Issues one 64-bit limb of b per cycle and tracks the multiplier's fixed pipeline latency.
- Accumulates the shifted partial products into a wide result register.
- Sits between the modular-multiplication datapath (valid/ready producer/consumer) and one shared 149x64 multiplier instance.

Parameters:
- A_W, 149, width of operand a and of the multiplier's a input.
- LIMB_W, 64, width of one limb and of the multiplier's b input.
- NUM_LIMBS, 4, number of limbs in operand b (>=1).
- MULT_LAT, 0, multiplier latency in cycles (0 = combinational). mul_p is valid MULT_LAT cycles after the cycle its operands are driven.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&&in_ready.
- in_a  in  A_W  operand a.
- in_b  in  LIMB_W*NUM_LIMBS  operand b, limb k = in_b[k*LIMB_W +: LIMB_W].
- mul_a  out  A_W  to multiplier a.
- mul_b  out  LIMB_W  to multiplier b.
- mul_p  in  A_W+LIMB_W  multiplier product.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_p  out  A_W+LIMB_W*NUM_LIMBS  product in_a*in_b.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Clock is clk. Reset is rst: asynchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_p=0, busy=0, mul_a=0, mul_b=0, limb counter=0, in-flight tag pipe cleared, operand registers 0.
- States:
  - IDLE: in_ready=1. On accept, register in_a and in_b, clear the accumulator, set limb counter=0, go to ISSUE.
  - ISSUE: each cycle drive mul_a=a_reg and mul_b=limb[cnt]. Push (valid=1, idx=cnt) into a MULT_LAT-deep tag pipe, then cnt++. After issuing limb NUM_LIMBS-1, go to DRAIN.
  - DRAIN: no issue; mul_b=0. Go to DONE when the tag pipe is empty and the last partial product has been accumulated.
  - DONE: out_valid=1, out_p=accumulator, both held stable until out_valid&&out_ready. Then go to IDLE, out_valid=0.
- Tag pipe: a shift register of (valid, idx) of depth MULT_LAT. When MULT_LAT=0 the tag is combinational from the current issue.
- Accumulation: when a tag emerges valid with index k, acc <= acc + (mul_p << (k*LIMB_W)). Width is A_W+LIMB_W*NUM_LIMBS, full precision, no overflow possible.
- Latency (accept edge = cycle 0):
  - Limbs are issued in cycles 1..NUM_LIMBS.
  - out_valid first rises in cycle NUM_LIMBS+MULT_LAT+1.
  - Defaults: cycle 5. With MULT_LAT=2: cycle 7.
- No new request is accepted before the result is consumed: in_ready=0 outside IDLE. No back-to-back overlap.
- out_ready stalls in DONE are unbounded; out_p must not change during the stall.
- mul_a and mul_b are combinational from state, operand registers and cnt. They must be stable for the whole issue cycle.
- Reset mid-operation aborts immediately. In-flight tags are discarded, so late mul_p values are never accumulated. out_valid=0.
- in_valid asserted while not in IDLE is ignored; no side effect.

Optional Feature:
- Macro: MULT_SKIP_ZERO_LIMB_EN.
- Defined:
  - At accept, compute a NUM_LIMBS-bit nonzero mask of in_b.
  - ISSUE visits only limbs with mask bit set, in ascending order, one per cycle, using a priority encoder on the remaining mask.
  - K = popcount(mask). out_valid rises in cycle K+MULT_LAT+1.
  - K=0: go IDLE->DONE directly, out_valid in cycle 1, out_p=0.
- Undefined: all limbs are always issued. Timing is exactly as in Behaviour.

Test Plan:
- Basic: in_a=1, in_b=1, out_ready=1 -> out_valid in cycle NUM_LIMBS+MULT_LAT+1 (5 at defaults), out_p=1, in_ready back to 1 the next cycle.
- Maximum operands: in_a=2^149-1, in_b=2^256-1 -> out_p=(2^149-1)*(2^256-1), all 405 bits checked. Repeat with MULT_LAT=2 -> out_valid in cycle 7.
- Limb placement: in_a=3, in_b=5<<192 (limb 3 only) -> out_p=15<<192. With MULT_SKIP_ZERO_LIMB_EN -> out_valid in cycle 2 at MULT_LAT=0. With MULT_SKIP_ZERO_LIMB_EN and in_b=0 -> out_valid in cycle 1, out_p=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_p and out_valid stable, in_ready=0, a second in_valid pulse is ignored. Then out_ready=1 for one cycle -> IDLE.
- Reset mid-operation: MULT_LAT=2, assert rst in cycle 2 -> all outputs go to reset values asynchronously. Then a new request in_a=7, in_b=6 -> out_p=42, no contamination from the aborted job.
- Random regression: 1000 random (in_a, in_b) with random out_ready gaps, against a reference multiply model.

Source files
------------

// File: rtl/mult_limb_seq.sv
// mult_limb_seq: sequences a wide A_W x (LIMB_W*NUM_LIMBS) unsigned multiply
// onto one external A_W x LIMB_W multiplier with MULT_LAT cycles of latency.
// One limb of b is issued per cycle. A tag pipe tracks which limb each
// in-flight product belongs to, and the shifted partial products are
// accumulated into a full-precision result.
// Optional feature macro: MULT_SKIP_ZERO_LIMB_EN (skip all-zero limbs of b).
module mult_limb_seq #(
  parameter int A_W       = 149,
  parameter int LIMB_W    = 64,
  parameter int NUM_LIMBS = 4,
  parameter int MULT_LAT  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [A_W-1:0]                in_a,
  input  logic [LIMB_W*NUM_LIMBS-1:0]   in_b,
  output logic [A_W-1:0]                mul_a,
  output logic [LIMB_W-1:0]             mul_b,
  input  logic [A_W+LIMB_W-1:0]         mul_p,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [A_W+LIMB_W*NUM_LIMBS-1:0] out_p,
  output logic                          busy
);

  localparam int B_W = LIMB_W * NUM_LIMBS;
  localparam int P_W = A_W + B_W;
  localparam int CW  = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]     state;
  logic [A_W-1:0] a_reg;
  logic [B_W-1:0] b_reg;
  logic [P_W-1:0] acc;
  logic           accept;
  logic           issue;
  logic [CW-1:0]  cur;         // limb index issued this cycle
  logic           last_issue;  // this cycle issues the final limb
  logic           tag_v;
  logic [CW-1:0]  tag_idx;
  logic           pipe_pending; // tags still in flight beyond the one emerging now

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_p     = acc;
  assign accept    = in_valid && in_ready;
  assign issue     = (state == ISSUE);
  assign mul_a     = issue ? a_reg : '0;
  assign mul_b     = issue ? b_reg[cur*LIMB_W +: LIMB_W] : '0;

`ifdef MULT_SKIP_ZERO_LIMB_EN
  logic [NUM_LIMBS-1:0] in_mask;
  logic [NUM_LIMBS-1:0] rem;
  logic                 found;

  // Nonzero mask of the incoming b limbs
  always_comb begin
    in_mask = '0;
    for (int unsigned k = 0; k < NUM_LIMBS; k++) in_mask[k] = |in_b[k*LIMB_W +: LIMB_W];
  end

  // Priority encoder: lowest remaining nonzero limb is issued next
  always_comb begin
    cur   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_LIMBS; k++) begin
      if (rem[k] && !found) begin
        cur   = CW'(k);
        found = 1'b1;
      end
    end
  end

  // rem & (rem-1) drops the lowest set bit, i.e. the limb being issued
  assign last_issue = ((rem & (rem - 1'b1)) == '0);

  // Remaining-limb mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rem <= '0;
    else if (accept) rem <= in_mask;
    else if (issue)  rem <= rem & (rem - 1'b1);
  end
`else
  logic [CW-1:0] cnt;

  assign cur        = cnt;
  assign last_issue = (cnt == CW'(NUM_LIMBS - 1));

  // Limb counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (accept)              cnt <= '0;
    else if (issue && last_issue) cnt <= '0;
    else if (issue)               cnt <= cnt + 1'b1;
  end
`endif

  generate
    if (MULT_LAT == 0) begin : g_tag_comb
      assign tag_v        = issue;
      assign tag_idx      = cur;
      assign pipe_pending = 1'b0;
    end else begin : g_tag_pipe
      logic [MULT_LAT-1:0] pv;
      logic [CW-1:0]       pi [MULT_LAT];

      // Shift (valid, idx) tags alongside the multiplier pipeline
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pv <= '0;
          for (int unsigned i = 0; i < MULT_LAT; i++) pi[i] <= '0;
        end else begin
          pv[0] <= issue;
          pi[0] <= cur;
          for (int unsigned i = 1; i < MULT_LAT; i++) begin
            pv[i] <= pv[i-1];
            pi[i] <= pi[i-1];
          end
        end
      end

      assign tag_v   = pv[MULT_LAT-1];
      assign tag_idx = pi[MULT_LAT-1];

      // Any tag behind the output stage means more products are coming
      always_comb begin
        pipe_pending = 1'b0;
        for (int unsigned i = 0; i + 1 < MULT_LAT; i++) pipe_pending = pipe_pending | pv[i];
      end
    end
  endgenerate

  // Control FSM. Leaving ISSUE/DRAIN on the same edge that accumulates the
  // last product lets out_valid rise in cycle K+MULT_LAT+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (accept) begin
`ifdef MULT_SKIP_ZERO_LIMB_EN
          state <= (in_mask == '0) ? DONE : ISSUE;
`else
          state <= ISSUE;
`endif
        end
        ISSUE: if (last_issue) state <= (MULT_LAT == 0) ? DONE : DRAIN;
        DRAIN: if (!pipe_pending) state <= DONE;
        DONE:  if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture and partial-product accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
    end else if (accept) begin
      a_reg <= in_a;
      b_reg <= in_b;
      acc   <= '0;
    end else if (tag_v) begin
      acc <= acc + (P_W'(mul_p) << (tag_idx * LIMB_W));
    end
  end

endmodule

// File: tb/tb_mult_limb_seq.sv
// Self-checking bench for mult_limb_seq: one instance at MULT_LAT=0 and one
// at MULT_LAT=2, each with its own behavioural multiplier.
// Honours MULT_SKIP_ZERO_LIMB_EN when computing expected latency.
module tb_mult_limb_seq;

  localparam int A_W    = 149;
  localparam int LIMB_W = 64;
  localparam int NL     = 4;
  localparam int B_W    = LIMB_W * NL;
  localparam int P_W    = A_W + B_W;
  localparam int M_W    = A_W + LIMB_W;

  logic              clk = 1'b0;
  logic              rst       [2];
  logic              in_valid  [2];
  logic              in_ready  [2];
  logic [A_W-1:0]    in_a      [2];
  logic [B_W-1:0]    in_b      [2];
  logic [A_W-1:0]    mul_a     [2];
  logic [LIMB_W-1:0] mul_b     [2];
  logic [M_W-1:0]    mul_p     [2];
  logic              out_valid [2];
  logic              out_ready [2];
  logic [P_W-1:0]    out_p     [2];
  logic              busy      [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_limb_seq #(.A_W(A_W), .LIMB_W(LIMB_W), .NUM_LIMBS(NL), .MULT_LAT(0)) dut0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .mul_a(mul_a[0]), .mul_b(mul_b[0]),
    .mul_p(mul_p[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_p(out_p[0]), .busy(busy[0])
  );

  mult_limb_seq #(.A_W(A_W), .LIMB_W(LIMB_W), .NUM_LIMBS(NL), .MULT_LAT(2)) dut1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .mul_a(mul_a[1]), .mul_b(mul_b[1]),
    .mul_p(mul_p[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_p(out_p[1]), .busy(busy[1])
  );

  // Behavioural multipliers: combinational, and a 2-stage pipeline that is
  // deliberately never reset so stale products keep flowing after a DUT reset
  logic [M_W-1:0] s1, s2;
  assign mul_p[0] = M_W'(mul_a[0]) * M_W'(mul_b[0]);
  always @(posedge clk) begin
    s1 <= M_W'(mul_a[1]) * M_W'(mul_b[1]);
    s2 <= s1;
  end
  assign mul_p[1] = s2;

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  // Expected cycle of first out_valid, counting the accept edge as cycle 0
  function automatic int model_lat(input logic [B_W-1:0] b, input int d);
    int k;
`ifdef MULT_SKIP_ZERO_LIMB_EN
    k = 0;
    for (int i = 0; i < NL; i++) if (b[i*LIMB_W +: LIMB_W] != '0) k++;
    if (k == 0) return 1;
`else
    k = NL;
`endif
    return k + lat_of(d) + 1;
  endfunction

  task automatic chk(input string nm, input logic [P_W-1:0] act, input logic [P_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Full request/response transaction with optional out_ready stall and an
  // ignored in_valid pulse during the stall
  task automatic txn(input int d, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                     input logic [P_W-1:0] exp_p, input int gap, input bit poke,
                     input string nm);
    int exp_lat;
    int cyc;
    exp_lat = model_lat(b, d);
    @(negedge clk);
    chk($sformatf("%s d%0d in_ready idle", nm, d), P_W'(in_ready[d]), 1);
    in_valid[d]  = 1'b1;
    in_a[d]      = a;
    in_b[d]      = b;
    out_ready[d] = 1'b0;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    in_a[d]     = ~a;
    in_b[d]     = ~b;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (out_valid[d] || cyc > 60) break;
    end
    chk($sformatf("%s d%0d latency", nm, d), P_W'(cyc), P_W'(exp_lat));
    chk($sformatf("%s d%0d out_p", nm, d), out_p[d], exp_p);
    chk($sformatf("%s d%0d in_ready done", nm, d), P_W'(in_ready[d]), 0);
    for (int g = 0; g < gap; g++) begin
      if (poke && g == 3) begin
        in_valid[d] = 1'b1;
        in_a[d]     = 149'd5;
        in_b[d]     = 256'd5;
      end
      if (poke && g == 5) in_valid[d] = 1'b0;
      @(negedge clk);
      chk($sformatf("%s d%0d stall valid", nm, d), P_W'(out_valid[d]), 1);
      chk($sformatf("%s d%0d stall out_p", nm, d), out_p[d], exp_p);
      chk($sformatf("%s d%0d stall in_ready", nm, d), P_W'(in_ready[d]), 0);
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk($sformatf("%s d%0d valid after consume", nm, d), P_W'(out_valid[d]), 0);
    chk($sformatf("%s d%0d in_ready after consume", nm, d), P_W'(in_ready[d]), 1);
    chk($sformatf("%s d%0d busy after consume", nm, d), P_W'(busy[d]), 0);
  endtask

  task automatic chk_reset_vals(input int d, input string nm);
    chk($sformatf("%s d%0d in_ready", nm, d), P_W'(in_ready[d]), 1);
    chk($sformatf("%s d%0d out_valid", nm, d), P_W'(out_valid[d]), 0);
    chk($sformatf("%s d%0d busy", nm, d), P_W'(busy[d]), 0);
    chk($sformatf("%s d%0d out_p", nm, d), out_p[d], '0);
    chk($sformatf("%s d%0d mul_a", nm, d), P_W'(mul_a[d]), '0);
    chk($sformatf("%s d%0d mul_b", nm, d), P_W'(mul_b[d]), '0);
  endtask

  typedef struct {
    int             d;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [P_W-1:0] p;
    int             gap;
    bit             poke;
  } vec_t;

  initial begin
    vec_t           vt [7];
    logic [A_W-1:0] amax;
    logic [B_W-1:0] bmax;
    logic [P_W-1:0] pmax;
    logic [A_W-1:0] ra;
    logic [B_W-1:0] rb;

    amax = '1;
    bmax = '1;
    // (2^149-1)(2^256-1) = 2^405 - 2^256 - 2^149 + 1, taken mod 2^405
    pmax = '0 - (P_W'(1) << 256) - (P_W'(1) << 149) + P_W'(1);

    vt[0] = '{d: 0, a: 149'd1,     b: 256'd1,           p: 405'd1,             gap: 0,  poke: 1'b0};
    vt[1] = '{d: 0, a: amax,       b: bmax,             p: pmax,               gap: 0,  poke: 1'b0};
    vt[2] = '{d: 1, a: amax,       b: bmax,             p: pmax,               gap: 1,  poke: 1'b0};
    vt[3] = '{d: 0, a: 149'd3,     b: 256'd5 << 192,    p: 405'd15 << 192,     gap: 0,  poke: 1'b0};
    vt[4] = '{d: 0, a: 149'd3,     b: 256'd0,           p: 405'd0,             gap: 0,  poke: 1'b0};
    vt[5] = '{d: 0, a: 149'd12345, b: 256'd678,         p: 405'd8369910,       gap: 10, poke: 1'b1};
    vt[6] = '{d: 1, a: 149'd3,     b: 256'd5 << 192,    p: 405'd15 << 192,     gap: 2,  poke: 1'b0};

    for (int d = 0; d < 2; d++) begin
      rst[d]       = 1'b1;
      in_valid[d]  = 1'b0;
      in_a[d]      = '0;
      in_b[d]      = '0;
      out_ready[d] = 1'b0;
    end
    #12;
    chk_reset_vals(0, "reset");
    chk_reset_vals(1, "reset");
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    for (int i = 0; i < 7; i++)
      txn(vt[i].d, vt[i].a, vt[i].b, vt[i].p, vt[i].gap, vt[i].poke, $sformatf("vec%0d", i));

    // Reset in cycle 2 of a MULT_LAT=2 job, then a clean follow-up request
    @(negedge clk);
    in_valid[1] = 1'b1;
    in_a[1]     = amax;
    in_b[1]     = bmax;
    @(posedge clk);
    #1 in_valid[1] = 1'b0;
    @(posedge clk);
    #2 rst[1] = 1'b1;
    #1;
    chk_reset_vals(1, "midrst");
    @(negedge clk);
    rst[1] = 1'b0;
    txn(1, 149'd7, 256'd6, 405'd42, 0, 1'b0, "post-rst");

    // Random regression against a plain multiply, limbs zeroed at random
    for (int i = 0; i < 1000; i++) begin
      ra = A_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
      for (int k = 0; k < NL; k++)
        rb[k*LIMB_W +: LIMB_W] = ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom};
      txn(i % 2, ra, rb, P_W'(ra) * P_W'(rb), int'($urandom_range(0, 3)), 1'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
